// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: pipeline-side status in, stall/flush/forward controls out.
// With HAZARD_PERF_COUNT_EN defined, also carries the three 32-bit performance counters.
interface pipeline_hazard_controller_if;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RDE, RDM, RDW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MemErr;
`ifdef HAZARD_PERF_COUNT_EN
  logic [31:0] LwStallCnt, FlushCnt, MemWaitCnt;
`endif

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RDE, RDM, RDW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemErr
`ifdef HAZARD_PERF_COUNT_EN
    , input LwStallCnt, FlushCnt, MemWaitCnt
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RDE, RDM, RDW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemErr
`ifdef HAZARD_PERF_COUNT_EN
    , output LwStallCnt, FlushCnt, MemWaitCnt
`endif
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// 5-stage pipeline hazard controller: forwarding, load-use/branch hazards, memory-wait freeze.
// Optional macro HAZARD_PERF_COUNT_EN adds LwStallCnt/FlushCnt/MemWaitCnt counters.
//
// state    | meaning
// RUN      | pipeline flowing; a not-ready memory access freezes it immediately
// MEM_WAIT | pipeline frozen until memory ready or wait_cnt reaches MEM_TIMEOUT
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input logic                          clk,
  input logic                          rst,
  pipeline_hazard_controller_if.slave  hz
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt, cnt_nxt;
  logic               err_set;
  logic               mem_err;
  logic               lw_stall, mem_stall;
  logic               lw_win, flush_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      if (err_set) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    err_set   = 1'b0;
    case (state)
      RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          state_nxt = MEM_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
          // access is abandoned; pipeline resumes with the error flagged
          err_set   = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (wait_cnt != '1) begin
          cnt_nxt   = wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.RDE != 5'd0) &&
                     ((hz.RDE == hz.Rs1D) || (hz.RDE == hz.Rs2D));
  assign mem_stall = ((state == RUN) && hz.MemReqM && !hz.MemReadyM) || (state == MEM_WAIT);
  assign flush_win = !mem_stall && hz.PCSrcE;
  assign lw_win    = !mem_stall && !hz.PCSrcE && lw_stall;

  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushW    = 1'b0;
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (!rst) begin
      if (hz.RegWriteM && hz.RDM != 5'd0 && hz.RDM == hz.Rs1E)      hz.ForwardAE = 2'b10;
      else if (hz.RegWriteW && hz.RDW != 5'd0 && hz.RDW == hz.Rs1E) hz.ForwardAE = 2'b01;
      if (hz.RegWriteM && hz.RDM != 5'd0 && hz.RDM == hz.Rs2E)      hz.ForwardBE = 2'b10;
      else if (hz.RegWriteW && hz.RDW != 5'd0 && hz.RDW == hz.Rs2E) hz.ForwardBE = 2'b01;

      if (mem_stall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.FlushW = 1'b1;
      end else if (flush_win) begin
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (lw_win) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
    end
  end

  assign hz.MemErr = mem_err;

`ifdef HAZARD_PERF_COUNT_EN
  logic [31:0] lw_cnt, flush_cnt, memwait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lw_cnt      <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (lw_win)    lw_cnt      <= lw_cnt + 32'd1;
      if (flush_win) flush_cnt   <= flush_cnt + 32'd1;
      if (mem_stall) memwait_cnt <= memwait_cnt + 32'd1;
    end
  end

  assign hz.LwStallCnt = lw_cnt;
  assign hz.FlushCnt   = flush_cnt;
  assign hz.MemWaitCnt = memwait_cnt;
`endif

endmodule
